byte_word_packer: RTL and testbench
===================================

// Module: byte_word_packer
// PURPOSE
//  Downstream consumer of the 8-bit registered byte stage (8-bit DFF bank, sync reset).
//  Accepts one byte per cycle over valid/ready and packs LANES bytes into one word.
//  The first accepted byte goes in lane 0 (LSBs). An in_last byte flushes a partial word with a keep mask.
//  Feeds word-wide consumers (FIFO/bus writer) over valid/ready.
// PARAMETERS
//  DATA_W  8  byte width; the upstream stage drives 8 bits
//  LANES   4  bytes per output word; legal range 2..8
// PORTS
//  clk        in   1               single clock; all state updates on posedge
//  resetn     in   1               synchronous, active-low reset; sampled on posedge clk
//  in_valid   in   1               in_data/in_last are valid
//  in_ready   out  1               packer can accept a byte this cycle
//  in_data    in   DATA_W          byte from the upstream register stage
//  in_last    in   1               this byte ends a packet; flush the word
//  out_valid  out  1               out_* hold a complete word
//  out_ready  in   1               downstream accepts the word
//  out_data   out  DATA_W*LANES    packed word; lane k = bits [k*DATA_W +: DATA_W]
//  out_keep   out  LANES           lane k is valid (thermometer from lane 0)
//  out_last   out  1               word ends a packet
//  out_parity out  LANES           only when BYTE_PACKER_PARITY_EN is defined
// BEHAVIOUR
//  - Reset (resetn==0 at posedge): out_valid=0, out_data=0, out_keep=0, out_last=0, lane count=0,
//    state=FILL, out_parity=0. Reset overrides any handshake in the same cycle.
//  - Reset mid-word discards the partial word and any unconsumed output word.
//  - Handshake: in xfer = in_valid&in_ready; out xfer = out_valid&out_ready.
//    in_ready = !out_valid | out_ready. This is combinational from out_ready; there is no other comb path.
//  - out_* stay stable while out_valid=1 and out_ready=0 (AXI-style hold). out_valid never drops without an out xfer.
//  - State FILL (out_valid=0):
//    - On an in xfer, write in_data into lane[cnt] and set keep[cnt]=1.
//    - If cnt==LANES-1 or in_last: go to HOLD, out_valid=1, out_last=in_last, cnt=0.
//    - Otherwise cnt=cnt+1.
//  - State HOLD (out_valid=1):
//    - On an out xfer with no in xfer: go to FILL, out_valid=0, clear data/keep/last.
//    - On an out xfer with an in xfer in the same cycle: the new byte starts a fresh word in lane 0.
//      All other lanes are cleared and keep=1 for lane 0 only.
//      If that byte has in_last (or LANES==1 is disallowed), stay in HOLD with the 1-byte word.
//  - Latency: word valid the cycle after the final byte is accepted.
//    Throughput: 1 byte/cycle sustained when out_ready=1.
//  - Unfilled lanes of a flushed word read as 0. out_keep is always a contiguous run from lane 0, never 0 when valid.
//  - in_last on lane LANES-1 gives a full word with out_last=1 (no extra empty word).
//  - cnt is a $clog2(LANES)-bit counter. It wraps to 0 only on word completion, never by overflow.
// CONFIGURATION
//  BYTE_PACKER_PARITY_EN defined:
//    - Adds out_parity[LANES]; bit k = ^lane k (even parity), and 0 for unkept lanes.
//    - Registered with out_data, so same timing and hold rules.
//  Undefined:
//    - The port and logic are absent. All other behaviour is identical.
// TESTING
//  T1 reset: resetn=0 for 2 clk with in_valid=1 -> out_valid=0, out_keep=0, in_ready=1 after release.
//  T2 full word: bytes 11,22,33,44 on 4 consecutive cycles, out_ready=1
//     -> next cycle out_data=32'h44332211, keep=4'hF, last=0.
//  T3 flush: bytes A5,5A with in_last on 5A -> out_data=32'h00005AA5, keep=4'h3, last=1.
//  T4 backpressure: word complete, out_ready=0 for 5 cycles -> out stable, in_ready=0.
//     Release with in_valid=1, byte 77 -> old word taken, next word lane0=77.
//  T5 reset mid-word: 2 bytes accepted, resetn=0 for 1 clk, then 01,02,03,04
//     -> out_data=32'h04030201, keep=4'hF.
//  T6 random: 400 cycles of random in_valid/out_ready/in_last and occasional resetn=0
//     -> scoreboard matches byte order, keep and last. With BYTE_PACKER_PARITY_EN, byte 8'h07 gives parity bit 1.

Source files
------------

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out valid/ready bundle for byte_word_packer.
// The packer binds the slave modport; the upstream byte source and the word sink bind master.
// out_parity exists only when BYTE_PACKER_PARITY_EN is defined.
interface byte_word_packer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANES  = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_W-1:0]         in_data;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W*LANES-1:0]   out_data;
   logic [LANES-1:0]          out_keep;
   logic                      out_last;
`ifdef BYTE_PACKER_PARITY_EN
   logic [LANES-1:0]          out_parity;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last, out_parity
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last, out_parity
   );
`else
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );
`endif
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs LANES bytes (lane 0 first) into one word over valid/ready.
// An in_last byte flushes a partial word with a thermometer keep mask; unfilled lanes read 0.
// Optional feature macro: BYTE_PACKER_PARITY_EN adds out_parity (even parity per kept lane).
// Reset is synchronous, active-low (resetn), and overrides any handshake in the same cycle.
module byte_word_packer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANES  = 4
) (
   input logic               clk,
   input logic               resetn,
   byte_word_packer_if.slave bus
);
   localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned WordW = DATA_W * LANES;

   localparam logic [0:0] StFill = 1'b0;
   localparam logic [0:0] StHold = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WordW-1:0] data_q, data_d;
   logic [LANES-1:0] keep_q, keep_d;
   logic             last_q, last_d;
   logic             valid_q, valid_d;
   logic             in_xfer, out_xfer;
   logic             cnt_full;

   // in_ready depends combinationally on out_ready only
   assign bus.in_ready  = !valid_q | bus.out_ready;
   assign in_xfer       = bus.in_valid & bus.in_ready;
   assign out_xfer      = valid_q & bus.out_ready;
   assign cnt_full      = (cnt_q == CntW'(LANES - 1));

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_keep  = keep_q;
   assign bus.out_last  = last_q;

   // Next-state: fill lanes in order, complete on last lane or in_last, restart on handoff
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;
      unique case (state_q)
         StFill: begin
            if (in_xfer) begin
               for (int unsigned k = 0; k < LANES; k++) begin
                  if (cnt_q == CntW'(k)) begin
                     data_d[k*DATA_W +: DATA_W] = bus.in_data;
                     keep_d[k]                  = 1'b1;
                  end
               end
               if (cnt_full || bus.in_last) begin
                  state_d = StHold;
                  valid_d = 1'b1;
                  last_d  = bus.in_last;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StHold: begin
            if (out_xfer) begin
               data_d = '0;
               keep_d = '0;
               last_d = 1'b0;
               if (in_xfer) begin
                  // Word handed off and a new byte arrives together: it opens a fresh word
                  data_d[DATA_W-1:0] = bus.in_data;
                  keep_d[0]          = 1'b1;
                  if (bus.in_last) begin
                     state_d = StHold;
                     valid_d = 1'b1;
                     last_d  = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = StFill;
                     valid_d = 1'b0;
                     cnt_d   = CntW'(1);
                  end
               end else begin
                  state_d = StFill;
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StFill;
         cnt_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

`ifdef BYTE_PACKER_PARITY_EN
   logic [LANES-1:0] parity_q, parity_d;

   // Parity follows next-state data so it registers alongside out_data and holds with it
   always_comb begin
      parity_d = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         parity_d[k] = keep_d[k] & (^data_d[k*DATA_W +: DATA_W]);
      end
   end

   // Parity register, cleared on reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         parity_q <= '0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and randomized self-checking bench for byte_word_packer (DATA_W=8, LANES=4).
module tb_byte_word_packer;
   logic clk;
   logic resetn;
   int   total;
   int   bad;

   byte_word_packer_if #(.DATA_W(8), .LANES(4)) bus ();

   byte_word_packer #(
      .DATA_W (8),
      .LANES  (4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic rdy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = rdy;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
      tick();
      total++;
      if ({bus.out_valid, bus.out_keep, bus.out_last} !== 6'b0) begin
         $display("FAIL reset_ctrl got v/k/l=%b exp=000000", {bus.out_valid, bus.out_keep, bus.out_last});
         bad++;
      end
      total++;
      if (bus.out_data !== 32'h0) begin
         $display("FAIL reset_data got=%h exp=00000000", bus.out_data);
         bad++;
      end
      resetn = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
         bad++;
      end
      tick();
   endtask

   task automatic test_full_word();
      drive(1'b1, 8'h11, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h22, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h33, 1'b0, 1'b1); tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         $display("FAIL full_early_valid got=%b exp=0", bus.out_valid);
         bad++;
      end
      drive(1'b1, 8'h44, 1'b0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
         $display("FAIL full_word got v=%b d=%h k=%h l=%b exp v=1 d=44332211 k=f l=0",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
         bad++;
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         $display("FAIL full_drain got=%b exp=0", bus.out_valid);
         bad++;
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 8'hA5, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h5A, 1'b1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, 32'h00005AA5, 4'h3, 1'b1}) begin
         $display("FAIL flush_partial got v=%b d=%h k=%h l=%b exp v=1 d=00005aa5 k=3 l=1",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
         bad++;
      end
      tick();
      // in_last on the final lane: full word, last set, no trailing empty word
      drive(1'b1, 8'hC1, 1'b0, 1'b1); tick();
      drive(1'b1, 8'hC2, 1'b0, 1'b1); tick();
      drive(1'b1, 8'hC3, 1'b0, 1'b1); tick();
      drive(1'b1, 8'hC4, 1'b1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, 32'hC4C3C2C1, 4'hF, 1'b1}) begin
         $display("FAIL flush_full got v=%b d=%h k=%h l=%b exp v=1 d=c4c3c2c1 k=f l=1",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
         bad++;
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         $display("FAIL flush_no_extra got=%b exp=0", bus.out_valid);
         bad++;
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 8'hB1, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hB2, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hB3, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hB4, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h99, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_keep, bus.out_last} !==
             {1'b1, 1'b0, 32'hB4B3B2B1, 4'hF, 1'b0}) begin
            $display("FAIL bp_hold[%0d] got v=%b rdy=%b d=%h k=%h l=%b exp v=1 rdy=0 d=b4b3b2b1 k=f l=0",
                     i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_keep, bus.out_last);
            bad++;
         end
         tick();
      end
      drive(1'b1, 8'h77, 1'b0, 1'b1);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
         bad++;
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         $display("FAIL bp_handoff_valid got=%b exp=0", bus.out_valid);
         bad++;
      end
      drive(1'b1, 8'h78, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h79, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h7A, 1'b0, 1'b1); tick();
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, 32'h7A797877, 4'hF, 1'b0}) begin
         $display("FAIL bp_next_word got v=%b d=%h k=%h l=%b exp v=1 d=7a797877 k=f l=0",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
         bad++;
      end
      // Handoff with a last byte in the same cycle: stays valid with a 1-byte word
      drive(1'b1, 8'h55, 1'b1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, 32'h00000055, 4'h1, 1'b1}) begin
         $display("FAIL bp_one_byte got v=%b d=%h k=%h l=%b exp v=1 d=00000055 k=1 l=1",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
         bad++;
      end
      tick();
   endtask

   task automatic test_reset_mid_word();
      drive(1'b1, 8'hE1, 1'b0, 1'b1); tick();
      drive(1'b1, 8'hE2, 1'b0, 1'b1); tick();
      resetn = 1'b0;
      drive(1'b1, 8'hE3, 1'b0, 1'b1); tick();
      resetn = 1'b1;
      total++;
      if ({bus.out_valid, bus.out_keep} !== 5'b0) begin
         $display("FAIL mid_reset got v/k=%b exp=00000", {bus.out_valid, bus.out_keep});
         bad++;
      end
      drive(1'b1, 8'h01, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h02, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h03, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h04, 1'b0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_keep} !== {1'b1, 32'h04030201, 4'hF}) begin
         $display("FAIL mid_word got v=%b d=%h k=%h exp v=1 d=04030201 k=f",
                  bus.out_valid, bus.out_data, bus.out_keep);
         bad++;
      end
      tick();
   endtask

`ifdef BYTE_PACKER_PARITY_EN
   task automatic test_parity();
      drive(1'b1, 8'h07, 1'b0, 1'b1); tick();
      drive(1'b1, 8'h03, 1'b1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if (bus.out_parity !== 4'b0001) begin
         $display("FAIL parity got=%b exp=0001", bus.out_parity);
         bad++;
      end
      tick();
   endtask
`endif

   task automatic test_random();
      logic [7:0]  part[$];
      logic [31:0] exp_data[$];
      logic [3:0]  exp_keep[$];
      logic        exp_last[$];
      logic [3:0]  exp_par[$];
      logic [31:0] w;
      logic [3:0]  kp;
      logic [3:0]  pr;
      logic        in_x;
      logic        out_x;
      resetn = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      resetn = 1'b1;
      for (int c = 0; c < 400; c++) begin
         resetn = ($urandom_range(0, 39) != 0);
         drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) != 0));
         #1;
         if (!resetn) begin
            part.delete();
            exp_data.delete();
            exp_keep.delete();
            exp_last.delete();
            exp_par.delete();
         end else begin
            total++;
            if (bus.out_valid !== (exp_data.size() != 0)) begin
               $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.out_valid, exp_data.size() != 0);
               bad++;
            end
            total++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
               $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, bus.in_ready,
                        !bus.out_valid || bus.out_ready);
               bad++;
            end
            in_x  = bus.in_valid & bus.in_ready;
            out_x = bus.out_valid & bus.out_ready;
            if (out_x && exp_data.size() != 0) begin
               total++;
               if ({bus.out_data, bus.out_keep, bus.out_last} !==
                   {exp_data[0], exp_keep[0], exp_last[0]}) begin
                  $display("FAIL rnd_word[%0d] got d=%h k=%h l=%b exp d=%h k=%h l=%b", c,
                           bus.out_data, bus.out_keep, bus.out_last,
                           exp_data[0], exp_keep[0], exp_last[0]);
                  bad++;
               end
`ifdef BYTE_PACKER_PARITY_EN
               total++;
               if (bus.out_parity !== exp_par[0]) begin
                  $display("FAIL rnd_parity[%0d] got=%b exp=%b", c, bus.out_parity, exp_par[0]);
                  bad++;
               end
`endif
               void'(exp_data.pop_front());
               void'(exp_keep.pop_front());
               void'(exp_last.pop_front());
               void'(exp_par.pop_front());
            end
            if (in_x) begin
               part.push_back(bus.in_data);
               if (part.size() == 4 || bus.in_last) begin
                  w  = '0;
                  kp = '0;
                  pr = '0;
                  foreach (part[i]) begin
                     w[i*8 +: 8] = part[i];
                     kp[i]       = 1'b1;
                     pr[i]       = ^part[i];
                  end
                  exp_data.push_back(w);
                  exp_keep.push_back(kp);
                  exp_last.push_back(bus.in_last);
                  exp_par.push_back(pr);
                  part.delete();
               end
            end
         end
         tick();
      end
      resetn = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      tick();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      test_reset();
      test_full_word();
      test_flush();
      test_backpressure();
      test_reset_mid_word();
`ifdef BYTE_PACKER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
